// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : two-requester (fetch / LSU) single-outstanding memory arbiter
//               with registered outputs, round-robin ties and a BUSY timeout.
//               Build option: MEM_ARB_LSU_PRIORITY_EN (LSU always wins ties).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic        IF_GNT,
  output logic        IF_VALID,
  output logic [31:0] IF_RDATA,
  input  logic        LSU_REQ,
  input  logic        LSU_WE,
  input  logic [3:0]  LSU_BE,
  input  logic [31:0] LSU_ADDR,
  input  logic [31:0] LSU_WDATA,
  output logic        LSU_GNT,
  output logic        LSU_VALID,
  output logic [31:0] LSU_RDATA,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [3:0]  MEM_BE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_READY,
  output logic        BUS_ERR
);

  localparam logic [8:0] c_TIMEOUT = 9'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic        r_owner_lsu;
  logic        w_any_req;
  logic        w_pick_lsu;
  logic        w_tout;
  logic [31:0] w_rsp_data;
`ifndef MEM_ARB_LSU_PRIORITY_EN
  logic        r_last_lsu;
`endif

  always_comb begin
    w_any_req   = IF_REQ | LSU_REQ;
`ifdef MEM_ARB_LSU_PRIORITY_EN
    w_pick_lsu  = LSU_REQ;
`else
    // On a tie the requester that was not granted last wins.
    w_pick_lsu  = LSU_REQ & (~IF_REQ | ~r_last_lsu);
`endif
    w_tout      = (r_state == S_BUSY) && !MEM_READY && (c_TIMEOUT != 9'd0) &&
                  (({1'b0, r_cnt} + 9'd1) == c_TIMEOUT);
    w_rsp_data  = (w_tout || MEM_WE) ? 32'd0 : MEM_RDATA;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_BUSY;
      S_BUSY:  if (MEM_READY || w_tout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt       <= 8'd0;
      r_owner_lsu <= 1'b0;
`ifndef MEM_ARB_LSU_PRIORITY_EN
      r_last_lsu  <= 1'b1;
`endif
      IF_GNT      <= 1'b0;
      IF_VALID    <= 1'b0;
      IF_RDATA    <= 32'd0;
      LSU_GNT     <= 1'b0;
      LSU_VALID   <= 1'b0;
      LSU_RDATA   <= 32'd0;
      MEM_REQ     <= 1'b0;
      MEM_WE      <= 1'b0;
      MEM_BE      <= 4'd0;
      MEM_ADDR    <= 32'd0;
      MEM_WDATA   <= 32'd0;
      BUS_ERR     <= 1'b0;
    end else begin
      IF_GNT    <= 1'b0;
      LSU_GNT   <= 1'b0;
      IF_VALID  <= 1'b0;
      LSU_VALID <= 1'b0;
      BUS_ERR   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner_lsu <= w_pick_lsu;
`ifndef MEM_ARB_LSU_PRIORITY_EN
            r_last_lsu  <= w_pick_lsu;
`endif
            IF_GNT      <= ~w_pick_lsu;
            LSU_GNT     <= w_pick_lsu;
            MEM_REQ     <= 1'b1;
            MEM_WE      <= w_pick_lsu ? LSU_WE    : 1'b0;
            MEM_BE      <= w_pick_lsu ? LSU_BE    : 4'hF;
            MEM_ADDR    <= w_pick_lsu ? LSU_ADDR  : IF_ADDR;
            MEM_WDATA   <= w_pick_lsu ? LSU_WDATA : 32'd0;
            r_cnt       <= 8'd0;
          end
        end
        S_BUSY: begin
          if (MEM_READY || w_tout) begin
            MEM_REQ   <= 1'b0;
            BUS_ERR   <= w_tout;
            IF_VALID  <= ~r_owner_lsu;
            LSU_VALID <= r_owner_lsu;
            if (r_owner_lsu) LSU_RDATA <= w_rsp_data;
            else             IF_RDATA  <= w_rsp_data;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255 (range 0..255): max BUSY cycles without MEM_READY before abort; 0 disables the timeout.
REQ-002 The block SHALL have these ports:
- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IF_REQ  in  1  fetch read request.
- IF_ADDR  in  32  fetch address.
- IF_GNT  out  1  fetch grant pulse.
- IF_VALID  out  1  fetch completion pulse.
- IF_RDATA  out  32  fetch read data.
- LSU_REQ  in  1  LSU request.
- LSU_WE  in  1  1=store, 0=load.
- LSU_BE  in  4  byte enables.
- LSU_ADDR  in  32  LSU address.
- LSU_WDATA  in  32  store data.
- LSU_GNT  out  1  LSU grant pulse.
- LSU_VALID  out  1  LSU completion pulse, for loads and stores.
- LSU_RDATA  out  32  load data.
- MEM_REQ  out  1  memory request, level.
- MEM_WE  out  1  memory write enable.
- MEM_BE  out  4  memory byte enables.
- MEM_ADDR  out  32  memory address.
- MEM_WDATA  out  32  memory write data.
- MEM_RDATA  in  32  memory read data.
- MEM_READY  in  1  memory done, sampled only while MEM_REQ=1.
- BUS_ERR  out  1  timeout flag, valid only with an *_VALID pulse.

Function
REQ-003 All outputs SHALL be registered; one transaction SHALL be outstanding at most; states are IDLE, BUSY, RESP.
REQ-004 In IDLE, at an edge where any REQ=1, the block SHALL pick a winner, latch its addr/we/be/wdata (IF: WE=0, BE=4'hF, WDATA=0), pulse the winner's GNT for exactly one cycle, assert MEM_REQ, clear the timeout counter, and enter BUSY.
REQ-005 Requester contract: hold REQ and its fields stable until GNT is seen, then drop REQ; REQ SHALL be ignored in BUSY and RESP, and REQ still high in IDLE SHALL be a new request.
REQ-006 Tie (both REQ=1 in IDLE): round-robin. The requester not granted last SHALL win; the LAST register updates on every grant.
REQ-007 In BUSY, MEM_* SHALL stay constant; at the first edge with MEM_READY=1, the block SHALL capture MEM_RDATA, drop MEM_REQ, and enter RESP with BUS_ERR=0.
REQ-008 In BUSY, the counter SHALL increment per edge without MEM_READY; when it reaches TIMEOUT_CYCLES (nonzero), the block SHALL drop MEM_REQ, force RDATA=0, set BUS_ERR=1, and enter RESP.
REQ-009 MEM_READY=1 on the same edge the timeout is reached SHALL complete normally (BUS_ERR=0).
REQ-010 RESP SHALL last exactly one cycle: the winner's VALID=1 with RDATA (stores: RDATA=0) and BUS_ERR; the next state SHALL be IDLE.
REQ-011 Latency: a request sampled at edge N, with MEM_READY at edge M≥N+1, SHALL give VALID high in cycle M..M+1; minimum 2 edges; peak rate one transaction per 3 cycles.
REQ-012 IF_RDATA/LSU_RDATA SHALL hold their last value except on own completion; the non-winner's VALID SHALL stay 0.

Reset
REQ-013 RST_N=0 SHALL immediately force state=IDLE, MEM_REQ/GNTs/VALIDs/BUS_ERR/MEM_WE=0, MEM_BE/MEM_ADDR/MEM_WDATA/RDATA=0, counter=0, and LAST=LSU, so IF wins the first tie.
REQ-014 Reset mid-BUSY SHALL abandon the transaction with no VALID; release SHALL be synchronous to CLK with the first arbitration at the first edge with RST_N=1.

Configuration
REQ-015 Macro MEM_ARB_LSU_PRIORITY_EN: if defined, LSU SHALL always win ties and LAST is unused; if undefined, REQ-006 round-robin applies.

Verification
REQ-016 Reset then IF_REQ, IF_ADDR=0x100, MEM_READY after 3 cycles, MEM_RDATA=0x00500093 -> IF_GNT 1 cycle, MEM_ADDR=0x100, MEM_WE=0, IF_VALID 1 cycle, IF_RDATA=0x00500093, BUS_ERR=0.
REQ-017 Both REQ in the same cycle, three times, each held until grant (macro off) -> grant order IF, LSU, IF; with macro on -> LSU, LSU, LSU.
REQ-018 LSU store ADDR=0x2004, BE=4'b0011, WDATA=0xDEADBEEF, MEM_READY immediate -> MEM_WE=1, MEM_BE=0011, MEM_WDATA=0xDEADBEEF, LSU_VALID pulse, LSU_RDATA=0.
REQ-019 TIMEOUT_CYCLES=4, MEM_READY held 0 -> MEM_REQ drops after 4 BUSY edges, VALID with BUS_ERR=1, RDATA=0; variant with MEM_READY on the 4th edge -> BUS_ERR=0.
REQ-020 RST_N low 2 cycles mid-BUSY -> outputs 0 asynchronously, no VALID, next request served normally, IF wins the first tie.
